mem_ctrl: RTL and testbench

Byte-serial memory controller that shares the single 8-bit synchronous on-board RAM between the instruction fetcher and the load/store unit. It accepts word fetches and 1/2/4-byte loads and stores, arbitrates round-robin, and sequences each access into consecutive byte cycles on the RAM port. It assembles read bytes little-endian and returns them with a one-cycle done pulse. It sits between the CPU core and the RAM, and supports aborting speculative reads on pipeline clear.

---
 rtl/mem_ctrl_pkg.sv | 27 ++
 rtl/mem_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial RAM controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  // Both 2'b10 and 2'b11 mean a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Shares one 8-bit synchronous RAM between fetch and load/store ports,
// round-robin arbitrated, one byte per cycle, little-endian assembly.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  clr_in,
  input  logic                  if_req_in,
  input  logic [31:0]           if_addr_in,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,
  input  logic                  ls_req_in,
  input  logic                  ls_we_in,
  input  logic [1:0]            ls_size_in,
  input  logic [31:0]           ls_addr_in,
  input  logic [31:0]           ls_wdata_in,
  output logic                  ls_done_out,
  output logic [31:0]           ls_rdata_out,
  output logic                  ram_en_out,
  output logic                  ram_r_nw_out,
  output logic [ADDR_WIDTH-1:0] ram_a_out,
  output logic [7:0]            ram_d_out,
  input  logic [7:0]            ram_d_in
);

  state_e                state_q;
  logic                  last_q;
  logic                  port_q;
  logic [2:0]            n_q;
  logic [2:0]            k_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           wdata_q;
  logic [31:0]           asm_q;
  logic                  ram_en_q;
  logic                  ram_rnw_q;
  logic [ADDR_WIDTH-1:0] ram_a_q;
  logic [7:0]            ram_d_q;
  logic                  if_done_q;
  logic [31:0]           if_data_q;
  logic                  ls_done_q;
  logic [31:0]           ls_rdata_q;

  logic                  gnt_if;
  logic                  gnt_ls;
  logic                  gnt_we;
  logic [31:0]           gnt_addr;
  logic [2:0]            k_inc;
  logic [ADDR_WIDTH-1:0] a_nxt;
  logic [7:0]            wbyte_nxt;
  logic [31:0]           asm_d;
  logic                  unused_addr_hi;

  // Fetch wins unless load/store is also asking and fetch was served last.
  always_comb begin
    gnt_if   = if_req_in && (!ls_req_in || last_q == PORT_LS);
    gnt_ls   = ls_req_in && !gnt_if;
    gnt_we   = gnt_ls && ls_we_in;
    gnt_addr = gnt_if ? if_addr_in : ls_addr_in;
    k_inc    = k_q + 3'd1;
    a_nxt    = base_q + ADDR_WIDTH'(k_inc);
    case (k_inc[1:0])
      2'd1:    wbyte_nxt = wdata_q[15:8];
      2'd2:    wbyte_nxt = wdata_q[23:16];
      2'd3:    wbyte_nxt = wdata_q[31:24];
      default: wbyte_nxt = wdata_q[7:0];
    endcase
    // Byte k-1 is on ram_d_in while address k is being issued.
    asm_d = asm_q;
    case (k_q)
      3'd1:    asm_d[7:0]   = ram_d_in;
      3'd2:    asm_d[15:8]  = ram_d_in;
      3'd3:    asm_d[23:16] = ram_d_in;
      3'd4:    asm_d[31:24] = ram_d_in;
      default: ;
    endcase
  end

  assign unused_addr_hi = ^gnt_addr[31:ADDR_WIDTH];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      last_q     <= PORT_LS;
      port_q     <= PORT_IF;
      n_q        <= 3'd0;
      k_q        <= 3'd0;
      base_q     <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      ram_en_q   <= 1'b0;
      ram_rnw_q  <= 1'b1;
      ram_a_q    <= '0;
      ram_d_q    <= '0;
      if_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_done_q  <= 1'b0;
      ls_rdata_q <= '0;
    end else begin
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!clr_in && (gnt_if || gnt_ls)) begin
            port_q    <= gnt_if ? PORT_IF : PORT_LS;
            last_q    <= gnt_if ? PORT_IF : PORT_LS;
            n_q       <= gnt_if ? 3'd4 : size_bytes(ls_size_in);
            base_q    <= gnt_addr[ADDR_WIDTH-1:0];
            wdata_q   <= ls_wdata_in;
            asm_q     <= '0;
            k_q       <= 3'd0;
            ram_en_q  <= 1'b1;
            ram_rnw_q <= !gnt_we;
            ram_a_q   <= gnt_addr[ADDR_WIDTH-1:0];
            if (gnt_we) ram_d_q <= ls_wdata_in[7:0];
            state_q   <= gnt_we ? WRITE : READ;
          end
        end
        READ: begin
          if (clr_in) begin
            ram_en_q  <= 1'b0;
            ram_rnw_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            asm_q <= asm_d;
            k_q   <= k_inc;
            if (k_q == n_q) begin
              if (port_q == PORT_IF) begin
                if_done_q <= 1'b1;
                if_data_q <= asm_d;
              end else begin
                ls_done_q  <= 1'b1;
                ls_rdata_q <= asm_d;
              end
              state_q <= DONE;
            end else if (k_inc == n_q) begin
              ram_en_q <= 1'b0;
            end else begin
              ram_a_q <= a_nxt;
            end
          end
        end
        WRITE: begin
          if (k_inc == n_q) begin
            ram_en_q  <= 1'b0;
            ram_rnw_q <= 1'b1;
            if (port_q == PORT_IF) if_done_q <= 1'b1;
            else                   ls_done_q <= 1'b1;
            state_q   <= DONE;
          end else begin
            k_q     <= k_inc;
            ram_a_q <= a_nxt;
            ram_d_q <= wbyte_nxt;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_en_out   = ram_en_q;
  assign ram_r_nw_out = ram_rnw_q;
  assign ram_a_out    = ram_a_q;
  assign ram_d_out    = ram_d_q;
  assign if_done_out  = if_done_q;
  assign if_data_out  = if_data_q;
  assign ls_done_out  = ls_done_q;
  assign ls_rdata_out = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural synchronous byte RAM.
module tb_mem_ctrl;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic          if_done;
  logic [31:0]   if_data;
  logic          ls_req = 1'b0;
  logic          ls_we = 1'b0;
  logic [1:0]    ls_size = 2'b00;
  logic [31:0]   ls_addr = '0;
  logic [31:0]   ls_wdata = '0;
  logic          ls_done;
  logic [31:0]   ls_rdata;
  logic          ram_en;
  logic          ram_rnw;
  logic [AW-1:0] ram_a;
  logic [7:0]    ram_wd;
  logic [7:0]    ram_rd = 8'h00;

  logic [7:0]    mem [0:(1<<AW)-1];

  int errors = 0;
  int checks = 0;

  mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk_in(clk), .rst_in(rst_n), .clr_in(clr),
    .if_req_in(if_req), .if_addr_in(if_addr),
    .if_done_out(if_done), .if_data_out(if_data),
    .ls_req_in(ls_req), .ls_we_in(ls_we), .ls_size_in(ls_size),
    .ls_addr_in(ls_addr), .ls_wdata_in(ls_wdata),
    .ls_done_out(ls_done), .ls_rdata_out(ls_rdata),
    .ram_en_out(ram_en), .ram_r_nw_out(ram_rnw), .ram_a_out(ram_a),
    .ram_d_out(ram_wd), .ram_d_in(ram_rd)
  );

  always #5 clk = ~clk;

  // RAM contents are (re)loaded while reset is held.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[17'h00000] <= 8'hA0; mem[17'h00001] <= 8'hA1;
      mem[17'h00002] <= 8'hA2; mem[17'h00003] <= 8'hA3;
      mem[17'h00020] <= 8'h55; mem[17'h00021] <= 8'h55;
      mem[17'h00022] <= 8'h55;
      mem[17'h00040] <= 8'h10; mem[17'h00041] <= 8'h20;
      mem[17'h00042] <= 8'h30; mem[17'h00043] <= 8'h40;
      mem[17'h00080] <= 8'h00; mem[17'h00081] <= 8'h00;
      mem[17'h00082] <= 8'h00; mem[17'h00083] <= 8'h00;
      mem[17'h00100] <= 8'h11; mem[17'h00101] <= 8'h22;
      mem[17'h00102] <= 8'h33; mem[17'h00103] <= 8'h44;
      mem[17'h1FFFE] <= 8'h5E; mem[17'h1FFFF] <= 8'h5F;
    end else if (ram_en) begin
      if (ram_rnw) ram_rd <= mem[ram_a];
      else         mem[ram_a] <= ram_wd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the selected done pulse; lat is the cycle index it appears in.
  task automatic wait_done(input bit ls, input int start, output int lat);
    lat = start;
    do begin
      step();
      lat++;
    end while (!(ls ? ls_done : if_done) && lat < 40);
  endtask

  task automatic run_if(input logic [31:0] addr, output logic [31:0] data, output int lat);
    if_req = 1'b1; if_addr = addr;
    wait_done(1'b0, 0, lat);
    data = if_data;
    if_req = 1'b0;
    step();
    chk("if_done_one_cycle", 32'(if_done), 32'd0);
  endtask

  task automatic run_ls(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] data, output int lat);
    ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = addr; ls_wdata = wd;
    wait_done(1'b1, 0, lat);
    data = ls_rdata;
    ls_req = 1'b0;
    step();
    chk("ls_done_one_cycle", 32'(ls_done), 32'd0);
  endtask

  initial begin
    int lat;
    int cnt;
    logic [31:0] d;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_en",    32'(ram_en),  32'd0);
    chk("rst_rnw",   32'(ram_rnw), 32'd1);
    chk("rst_a",     32'(ram_a),   32'd0);
    chk("rst_d",     32'(ram_wd),  32'd0);
    chk("rst_done",  32'({if_done, ls_done}), 32'd0);
    chk("rst_idata", if_data,  32'd0);
    chk("rst_ldata", ls_rdata, 32'd0);
    rst_n = 1'b1;

    // Tie from reset: fetch first, then load; a fresh fetch then loses to the waiting load.
    if_req = 1'b1; if_addr = 32'h0;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h40;
    step();
    chk("arb1_fetch_first", 32'(ram_a), 32'h0);
    chk("arb1_rnw", 32'(ram_rnw), 32'd1);
    wait_done(1'b0, 1, lat);
    chk("arb1_fetch_lat", lat, 6);
    chk("arb1_fetch_data", if_data, 32'hA3A2A1A0);
    if_req = 1'b0;
    step();
    chk("arb1_done_idle_en", 32'(ram_en), 32'd0);
    if_req = 1'b1; if_addr = 32'h100;
    step();
    chk("arb2_load_first", 32'(ram_a), 32'h40);
    wait_done(1'b1, 1, lat);
    chk("arb2_load_lat", lat, 6);
    chk("arb2_load_data", ls_rdata, 32'h40302010);
    ls_req = 1'b0;
    wait_done(1'b0, 0, lat);
    chk("arb2_fetch_lat", lat, 7);
    chk("arb2_fetch_data", if_data, 32'h44332211);
    if_req = 1'b0;
    step();
    chk("arb2_done_pulse", 32'(if_done), 32'd0);

    // Plain fetch with per-cycle bus checks.
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("fetch_en", 32'(ram_en), 32'd1);
      chk("fetch_addr", 32'(ram_a), 32'h100 + 32'(c - 1));
    end
    step();
    chk("fetch_c5_en", 32'(ram_en), 32'd0);
    chk("fetch_c5_done", 32'(if_done), 32'd0);
    step();
    chk("fetch_c6_done", 32'(if_done), 32'd1);
    chk("fetch_data", if_data, 32'h44332211);
    if_req = 1'b0;
    step();
    chk("fetch_data_hold", if_data, 32'h44332211);

    // Half store at 0x20.
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b01; ls_addr = 32'h20; ls_wdata = 32'hAABBCCDD;
    step();
    chk("sth_c1", {ram_en, ram_rnw, 7'(ram_a), ram_wd}, {1'b1, 1'b0, 7'h20, 8'hDD});
    step();
    chk("sth_c2", {ram_en, ram_rnw, 7'(ram_a), ram_wd}, {1'b1, 1'b0, 7'h21, 8'hCC});
    step();
    chk("sth_c3_done", 32'(ls_done), 32'd1);
    chk("sth_c3_idle", 32'({ram_en, ram_rnw}), 32'b01);
    ls_req = 1'b0;
    step();
    chk("sth_mem", {8'h00, mem[17'h22], mem[17'h21], mem[17'h20]}, 32'h0055CCDD);
    run_ls(1'b0, 2'b00, 32'h21, 32'h0, d, lat);
    chk("ldb_data", d, 32'h000000CC);
    chk("ldb_lat", lat, 3);

    // Wrap at top of RAM; upper address bits are dropped.
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b11; ls_addr = 32'h0003FFFE;
    step(); chk("wrap_a0", 32'(ram_a), 32'h1FFFE);
    step(); chk("wrap_a1", 32'(ram_a), 32'h1FFFF);
    step(); chk("wrap_a2", 32'(ram_a), 32'h00000);
    step(); chk("wrap_a3", 32'(ram_a), 32'h00001);
    wait_done(1'b1, 4, lat);
    chk("wrap_lat", lat, 6);
    chk("wrap_data", ls_rdata, 32'hA1A05F5E);
    ls_req = 1'b0;
    step();

    // Clear in IDLE suppresses the grant for that cycle only.
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 32'h100; clr = 1'b1;
    step();
    chk("clr_idle_nogrant", 32'(ram_en), 32'd0);
    clr = 1'b0;
    wait_done(1'b1, 0, lat);
    chk("clr_idle_lat", lat, 3);
    chk("clr_idle_data", ls_rdata, 32'h00000011);
    ls_req = 1'b0;
    step();

    // Clear in cycle 3 of a fetch aborts it.
    if_req = 1'b1; if_addr = 32'h100;
    step(); step(); step();
    clr = 1'b1;
    step();
    clr = 1'b0; if_req = 1'b0;
    chk("clr_rd_en", 32'(ram_en), 32'd0);
    chk("clr_rd_rnw", 32'(ram_rnw), 32'd1);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (if_done) cnt++;
      step();
    end
    chk("clr_rd_nodone", cnt, 0);
    chk("clr_rd_data_hold", if_data, 32'h44332211);

    // Clear in cycle 2 of a word store is ignored.
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h80; ls_wdata = 32'h11223344;
    step(); step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_wr_c3", {ram_en, ram_rnw, 7'(ram_a), ram_wd}, {1'b1, 1'b0, 7'h02, 8'h22});
    wait_done(1'b1, 3, lat);
    chk("clr_wr_lat", lat, 5);
    ls_req = 1'b0;
    step();
    chk("clr_wr_mem", {mem[17'h83], mem[17'h82], mem[17'h81], mem[17'h80]}, 32'h11223344);

    // Asynchronous reset in the middle of a read.
    if_req = 1'b1; if_addr = 32'h100;
    step(); step(); step();
    chk("mrst_pre_en", 32'(ram_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_bus", {ram_en, ram_rnw, 7'(ram_a), ram_wd}, {1'b0, 1'b1, 7'h00, 8'h00});
    chk("mrst_done", 32'({if_done, ls_done}), 32'd0);
    chk("mrst_idata", if_data, 32'd0);
    chk("mrst_ldata", ls_rdata, 32'd0);
    if_req = 1'b0;
    step(); step();
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (if_done || ls_done) cnt++;
      step();
    end
    chk("mrst_nodone", cnt, 0);
    run_if(32'h100, d, lat);
    chk("mrst_fresh_lat", lat, 6);
    chk("mrst_fresh_data", d, 32'h44332211);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
